approx_mul_err_monitor: RTL and testbench

//  Downstream checker for the generated approximate 2x2-bit multipliers (4 in, 4 out).

---
 rtl/approx_mul_err_monitor_pkg.sv | 21 ++
 rtl/approx_mul_err_monitor_if.sv | 38 +++
 rtl/approx_mul_err_monitor_stats.sv | 62 ++++++
 rtl/approx_mul_err_monitor.sv | 97 +++++++++
 tb/tb_approx_mul_err_monitor.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/approx_mul_err_monitor_pkg.sv
// approx_mon_pkg: shared widths, stats FSM states and the sample record for the approx-multiplier monitor
package approx_mon_pkg;

    localparam int DEF_OP_W  = 2;
    localparam int DEF_P_W   = 2 * DEF_OP_W;
    localparam int DEF_ET    = 2;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } mon_state_e;

    typedef struct packed {
        logic [DEF_OP_W-1:0] op_a;
        logic [DEF_OP_W-1:0] op_b;
        logic [DEF_P_W-1:0]  approx_p;
    } sample_t;

endpackage

// File: rtl/approx_mul_err_monitor_if.sv
// approx_mul_err_monitor_if: sample stream, result stream and statistics of the error monitor
interface approx_mul_err_monitor_if
    import approx_mon_pkg::*;
#(
    parameter int OP_W  = DEF_OP_W,
    parameter int P_W   = DEF_P_W,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [P_W-1:0]   approx_p;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [P_W-1:0]   exact_p;
    logic [P_W-1:0]   abs_err;
    logic             err_viol;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] viol_cnt;
    logic [P_W-1:0]   max_err;
    logic             err_sticky;

    modport slave (
        input  in_valid, op_a, op_b, approx_p, clear, out_ready,
        output in_ready, out_valid, exact_p, abs_err, err_viol,
               sample_cnt, viol_cnt, max_err, err_sticky
    );

    modport master (
        output in_valid, op_a, op_b, approx_p, clear, out_ready,
        input  in_ready, out_valid, exact_p, abs_err, err_viol,
               sample_cnt, viol_cnt, max_err, err_sticky
    );

endinterface

// File: rtl/approx_mul_err_monitor_stats.sv
// approx_mon_stats: retire-time error statistics with saturation gate FSM and clear priority
module approx_mon_stats
    import approx_mon_pkg::*;
#(
    parameter int P_W   = DEF_P_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_hs,
    input  logic             retire,
    input  logic [P_W-1:0]   abs_err,
    input  logic             err_viol,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [P_W-1:0]   max_err,
    output logic             err_sticky
);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
    logic [P_W-1:0]   max_err_q, max_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic             cnt_en;

    // Counters freeze once saturated (SAT); max/sticky keep tracking; clear beats a same-cycle retire
    always_comb begin
        cnt_en       = retire && (state_q != SAT);
        sample_cnt_d = clear ? '0 : ((cnt_en && !(&sample_cnt_q)) ? sample_cnt_q + 1'b1 : sample_cnt_q);
        viol_cnt_d   = clear ? '0 : ((cnt_en && err_viol && !(&viol_cnt_q)) ? viol_cnt_q + 1'b1 : viol_cnt_q);
        max_err_d    = clear ? '0 : ((retire && (abs_err > max_err_q)) ? abs_err : max_err_q);
        err_sticky_d = clear ? 1'b0 : (err_sticky_q || (retire && err_viol));
        state_d      = clear ? IDLE :
                       ((state_q == IDLE) && in_hs) ? RUN :
                       ((state_q == RUN) && (&sample_cnt_d)) ? SAT : state_q;
    end

    // Statistics and FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            viol_cnt_q   <= '0;
            max_err_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            viol_cnt_q   <= viol_cnt_d;
            max_err_q    <= max_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign viol_cnt   = viol_cnt_q;
    assign max_err    = max_err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor: two-stage exact-vs-approximate product checker with running error statistics
module approx_mul_err_monitor
    import approx_mon_pkg::*;
#(
    parameter int OP_W  = DEF_OP_W,
    parameter int P_W   = DEF_P_W,
    parameter int ET    = DEF_ET,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic                    clk,
    input logic                    rst_n,
    approx_mul_err_monitor_if.slave bus
);

    if ((P_W != 2 * OP_W) || (OP_W != DEF_OP_W)) begin : g_bad_width
        $error("approx_mul_err_monitor: P_W must be 2*OP_W and OP_W must match the sample record");
    end
    if (ET >= 2 ** P_W) begin : g_bad_et
        $error("approx_mul_err_monitor: ET must be below 2**P_W");
    end

    logic           s1_valid_q, s1_valid_d;
    sample_t        s1_q, s1_d;
    logic [P_W-1:0] s1_exact_q, s1_exact_d;
    logic           s2_valid_q, s2_valid_d;
    logic [P_W-1:0] exact_q, exact_d;
    logic [P_W-1:0] abs_q, abs_d;
    logic           viol_q, viol_d;
    logic [P_W-1:0] diff;
    logic           s1_adv, s2_adv, in_hs, retire, ld2;

    // Backpressure chain: a stage may take new data when empty or when the stage after it moves
    always_comb begin
        s2_adv = !s2_valid_q || bus.out_ready;
        s1_adv = !s1_valid_q || s2_adv;
        in_hs  = bus.in_valid && s1_adv;
        retire = s2_valid_q && bus.out_ready;
        ld2    = s2_adv && s1_valid_q;
    end

    // Stage data: S1 captures the sample and exact product, S2 the error and violation flag
    always_comb begin
        diff       = (s1_exact_q >= s1_q.approx_p) ? s1_exact_q - s1_q.approx_p : s1_q.approx_p - s1_exact_q;
        s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
        s1_d       = in_hs ? {bus.op_a, bus.op_b, bus.approx_p} : s1_q;
        s1_exact_d = in_hs ? P_W'(bus.op_a) * P_W'(bus.op_b) : s1_exact_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        exact_d    = ld2 ? s1_exact_q : exact_q;
        abs_d      = ld2 ? diff : abs_q;
        viol_d     = ld2 ? (diff > P_W'(ET)) : viol_q;
    end

    // Pipeline registers; reset drops any in-flight samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_exact_q <= '0;
            s2_valid_q <= 1'b0;
            exact_q    <= '0;
            abs_q      <= '0;
            viol_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s1_exact_q <= s1_exact_d;
            s2_valid_q <= s2_valid_d;
            exact_q    <= exact_d;
            abs_q      <= abs_d;
            viol_q     <= viol_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.exact_p   = exact_q;
    assign bus.abs_err   = abs_q;
    assign bus.err_viol  = viol_q;

    approx_mon_stats #(
        .P_W   (P_W),
        .CNT_W (CNT_W)
    ) u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (bus.clear),
        .in_hs      (in_hs),
        .retire     (retire),
        .abs_err    (abs_q),
        .err_viol   (viol_q),
        .sample_cnt (bus.sample_cnt),
        .viol_cnt   (bus.viol_cnt),
        .max_err    (bus.max_err),
        .err_sticky (bus.err_sticky)
    );

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// tb_approx_mul_err_monitor: directed checks of the approximate-multiplier error monitor
module tb_approx_mul_err_monitor;
    import approx_mon_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   va [32];
    int   vb [32];
    int   vp [32];
    bit   stalled;
    int   exp_max;

    approx_mul_err_monitor_if #(.OP_W(2), .P_W(4), .CNT_W(4)) bus ();

    approx_mul_err_monitor #(.OP_W(2), .P_W(4), .ET(2), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input int a, input int b, input int p);
        int e, d;
        e = a * b;
        d = (e >= p) ? e - p : p - e;
        return {4'(e), 4'(d), d > 2};
    endfunction

    task automatic stats(input string tag, input int sc, input int vc, input int mx, input int st);
        check({tag, "_sample_cnt"}, 32'(bus.sample_cnt), sc);
        check({tag, "_viol_cnt"}, 32'(bus.viol_cnt), vc);
        check({tag, "_max_err"}, 32'(bus.max_err), mx);
        check({tag, "_sticky"}, 32'(bus.err_sticky), st);
    endtask

    task automatic run_one(input string tag, input logic [1:0] a, input logic [1:0] b, input logic [3:0] ap,
                           input logic [3:0] ee, input logic [3:0] ea, input logic ev);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.approx_p  = ap;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 32'(bus.out_valid), 0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_result"}, {bus.exact_p, bus.abs_err, bus.err_viol}, {ee, ea, ev});
        @(negedge clk);
        check({tag, "_drained"}, 32'(bus.out_valid), 0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic stream(input string tag, input int n, input int stall, output bit stl);
        logic [8:0] q[$];
        int idx = 0;
        int ret = 0;
        stl = 1'b0;
        for (int cyc = 0; cyc < n + stall + 20 && ret < n; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= stall);
            bus.in_valid  = (idx < n);
            if (idx < n) begin
                bus.op_a     = 2'(va[idx]);
                bus.op_b     = 2'(vb[idx]);
                bus.approx_p = 4'(vp[idx]);
            end
            #1;
            if (bus.in_valid && !bus.in_ready) stl = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                check({tag, "_result"}, {bus.exact_p, bus.abs_err, bus.err_viol}, q.size() > 0 ? q.pop_front() : 9'h1ff);
                ret++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(va[idx], vb[idx], vp[idx]));
                idx++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, "_retired"}, ret, n);
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.approx_p  = '0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_exact", 32'(bus.exact_p), 0);
        stats("rst", 0, 0, 0, 0);
        check("rst_state", 32'(dut.u_stats.state_q), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        run_one("t1", 2'd3, 2'd3, 4'd9, 4'd9, 4'd0, 1'b0);
        stats("t1", 1, 0, 0, 0);
        check("t1_state", 32'(dut.u_stats.state_q), 32'(RUN));

        run_one("t2", 2'd2, 2'd3, 4'd2, 4'd6, 4'd4, 1'b1);
        stats("t2", 2, 1, 4, 1);

        run_one("t3", 2'd3, 2'd1, 4'd1, 4'd3, 4'd2, 1'b0);
        stats("t3", 3, 1, 4, 1);

        do_clear();
        stats("clr", 0, 0, 0, 0);
        check("clr_state", 32'(dut.u_stats.state_q), 32'(IDLE));

        va[0] = 0; vb[0] = 0; vp[0] = 5;
        va[1] = 1; vb[1] = 2; vp[1] = 2;
        va[2] = 3; vb[2] = 2; vp[2] = 7;
        va[3] = 2; vb[3] = 2; vp[3] = 4;
        stream("t4", 4, 3, stalled);
        check("t4_stalled", 32'(stalled), 1);
        stats("t4", 4, 1, 5, 1);

        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op_a = 2'd2; bus.op_b = 2'd3; bus.approx_p = 4'd2;
        @(negedge clk);
        bus.op_a = 2'd3; bus.op_b = 2'd3; bus.approx_p = 4'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clear    = 1'b1;
        check("t5_first", {bus.out_valid, bus.exact_p, bus.abs_err, bus.err_viol}, {1'b1, 4'd6, 4'd4, 1'b1});
        @(negedge clk);
        bus.clear = 1'b0;
        stats("t5", 0, 0, 0, 0);
        check("t5_state", 32'(dut.u_stats.state_q), 32'(IDLE));
        check("t5_second", {bus.out_valid, bus.exact_p, bus.abs_err, bus.err_viol}, {1'b1, 4'd9, 4'd9, 1'b1});
        @(negedge clk);
        do_clear();

        for (int i = 0; i < 17; i++) begin
            va[i] = 1; vb[i] = 1; vp[i] = 1;
        end
        stream("t6", 17, 0, stalled);
        check("t6_no_stall", 32'(stalled), 0);
        stats("t6", 15, 0, 0, 0);
        check("t6_state", 32'(dut.u_stats.state_q), 32'(SAT));
        run_one("t6v", 2'd2, 2'd3, 4'd2, 4'd6, 4'd4, 1'b1);
        stats("t6v", 15, 0, 4, 1);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_a = 2'd1; bus.op_b = 2'd1; bus.approx_p = 4'd1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6r_out_valid", 32'(bus.out_valid), 0);
        stats("t6r", 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        exp_max = 0;
        for (int i = 0; i < 16; i++) begin
            logic [8:0] m;
            va[i] = i % 4;
            vb[i] = i / 4;
            vp[i] = (i * 5 + 3) % 16;
            m = model(va[i], vb[i], vp[i]);
            if (int'(m[4:1]) > exp_max) exp_max = int'(m[4:1]);
        end
        stream("ex", 16, 2, stalled);
        check("ex_sample_cnt", 32'(bus.sample_cnt), 15);
        check("ex_max_err", 32'(bus.max_err), exp_max);
        check("ex_sticky", 32'(bus.err_sticky), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
